commit_trace_fifo: RTL and testbench
====================================

COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of trace entries; it must be a power of two and at least 2.
REQ-002 SHALL have parameter START_PC, default 64'h80000000, meaning the PC of the commit that arms capture.
REQ-003 clk  in  1  rising-edge clock; the only clock.
REQ-004 rstn  in  1  reset, synchronous and active-low.
REQ-005 commit  in  1  core commit strobe.
REQ-006 stall_exe  in  1  execute stall; a commit is valid only when this is low.
REQ-007 pc  in  64  committed PC, already sign-extended.
REQ-008 instr  in  32  committed instruction word.
REQ-009 xreg_dest  in  5  destination integer register.
REQ-010 wr_en  in  1  integer register-file write enable.
REQ-011 commit_data  in  64  writeback data.
REQ-012 excep / csr_excep_valid  in  1 each  exception indications.
REQ-013 csr_cause  in  64  exception cause.
REQ-014 out_valid / out_ready  out / in  1 each  consumer handshake.
REQ-015 out_pc[64], out_instr[32], out_dest[5], out_data[64], out_wr_valid[1], out_excep[1], out_cause[64], out_seq[32]  out  head-entry fields.
REQ-016 armed  out  1  capture is enabled.
REQ-017 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-018 overflow  out  1  sticky flag: at least one event was dropped.
REQ-019 drop_cnt  out  16  saturating count of dropped events.

Function
REQ-020 An event SHALL be defined as commit && !stall_exe in a given cycle.
REQ-021 While armed=0, events with pc != START_PC SHALL be discarded with no effect on any state; they do not count as drops.
REQ-022 An event with pc == START_PC while armed=0 SHALL set armed=1 on the next edge, and that event SHALL itself be captured.
REQ-023 armed SHALL stay 1 until reset.
REQ-024 A captured entry SHALL store the following fields:
  - pc, instr, xreg_dest, commit_data
  - wr_valid = wr_en && (xreg_dest != 0)
  - excep_any = excep || csr_excep_valid
  - cause = csr_cause when excep_any is 1, else 0
  - seq = current sequence counter value
REQ-025 The sequence counter SHALL start at 0, increment by 1 per captured entry only, and wrap from 2^32-1 to 0.
REQ-026 Storage SHALL be a circular buffer with read/write pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
REQ-027 Output SHALL be first-word fall-through: out_valid = (count != 0), and the out_* fields present the head entry combinationally from storage.
REQ-028 A pop SHALL occur when out_valid && out_ready; the head advances on that edge.
REQ-029 Push latency SHALL be one cycle: an event captured at edge N into an empty FIFO yields out_valid=1 after edge N.
REQ-030 A push with no pop SHALL increment count; a pop with no push SHALL decrement count; a simultaneous push and pop SHALL leave count unchanged.
REQ-031 When full (count == DEPTH) and a pop occurs in the same cycle, the push SHALL be accepted.
REQ-032 When full with no pop, the event SHALL be dropped: overflow is set, drop_cnt increments (saturating at 16'hFFFF), the sequence counter does not advance, and the stored entries are unchanged.
REQ-033 out_ready while out_valid=0 SHALL have no effect.
REQ-034 out_* field values while out_valid=0 are don't-care.

Reset
REQ-035 When rstn=0 at an edge, the following SHALL be cleared: armed, count, both pointers, the sequence counter, overflow, and drop_cnt. As a result out_valid=0.
REQ-036 Reset SHALL take priority over a simultaneous event or pop.
REQ-037 Reset asserted mid-stream SHALL discard all entries, and re-arming SHALL again require pc == START_PC.
REQ-038 Storage contents need no reset.

Verification
REQ-039 Arming: events at pc 0x1000, 0x1004, then 0x80000000 with out_ready=0 -> only the 0x80000000 entry is present, count=1, seq=0, armed=1.
REQ-040 Throughput: after arming, 20 back-to-back events with out_ready=1 -> every entry is delivered in order, seq runs 0..19, count never exceeds 1, overflow=0.
REQ-041 Overflow: DEPTH=8, out_ready=0, 10 events after arming -> count=8, overflow=1, drop_cnt=2, and the head is seq 0; then drain -> seq 0..7 delivered, no gaps.
REQ-042 Full with simultaneous pop: full FIFO, event plus out_ready=1 in the same cycle -> count stays 8, drop_cnt is unchanged, and the new entry's seq is 8.
REQ-043 Field rules:
  - wr_en=1, xreg_dest=0 -> out_wr_valid=0.
  - csr_excep_valid=1, csr_cause=64'h2 -> out_excep=1, out_cause=2.
  - stall_exe=1 with commit=1 -> nothing is captured.
REQ-044 Reset mid-stream: count=5, then rstn=0 for one edge concurrent with an event -> count=0, armed=0, drop_cnt=0; a following pc 0x1000 event is discarded.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// Commit trace capture FIFO: arms on the first commit at START_PC, then records every
// valid commit into a first-word fall-through circular buffer, counting drops when full.
module commit_trace_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [63:0] START_PC = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     commit,
    input  logic                     stall_exe,
    input  logic [63:0]              pc,
    input  logic [31:0]              instr,
    input  logic [4:0]               xreg_dest,
    input  logic                     wr_en,
    input  logic [63:0]              commit_data,
    input  logic                     excep,
    input  logic                     csr_excep_valid,
    input  logic [63:0]              csr_cause,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [4:0]               out_dest,
    output logic [63:0]              out_data,
    output logic                     out_wr_valid,
    output logic                     out_excep,
    output logic [63:0]              out_cause,
    output logic [31:0]              out_seq,
    output logic                     armed,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  dest;
        logic [63:0] data;
        logic        wr_valid;
        logic        excep;
        logic [63:0] cause;
        logic [31:0] seq;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    logic            armed_q, armed_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     seq_q, seq_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic            evt, capture, full, push, pop, drop, excep_any;

    always_comb begin
        evt       = commit && !stall_exe;
        // Unarmed FIFO is always empty, so the arming event can never be dropped.
        capture   = evt && (armed_q || (pc == START_PC));
        full      = (count_q == FullCount);
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready;
        push      = capture && (!full || pop);
        drop      = capture && full && !pop;
        excep_any = excep || csr_excep_valid;

        wr_entry.pc       = pc;
        wr_entry.instr    = instr;
        wr_entry.dest     = xreg_dest;
        wr_entry.data     = commit_data;
        wr_entry.wr_valid = wr_en && (xreg_dest != 5'd0);
        wr_entry.excep    = excep_any;
        wr_entry.cause    = excep_any ? csr_cause : 64'd0;
        wr_entry.seq      = seq_q;
    end

    always_comb begin
        armed_d    = armed_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (capture) begin
            armed_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            seq_d    = seq_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            armed_q    <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= 32'd0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            armed_q    <= armed_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && rstn) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head         = mem_q[rd_ptr_q];
        out_pc       = head.pc;
        out_instr    = head.instr;
        out_dest     = head.dest;
        out_data     = head.data;
        out_wr_valid = head.wr_valid;
        out_excep    = head.excep;
        out_cause    = head.cause;
        out_seq      = head.seq;
        armed        = armed_q;
        count        = count_q;
        overflow     = overflow_q;
        drop_cnt     = drop_cnt_q;
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: stimulus pushes expected entries, a forked
// monitor pops and compares on every output handshake.
module tb_commit_trace_fifo;

    localparam logic [63:0] StartPc = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  dest;
        logic [63:0] data;
        logic        wr_valid;
        logic        excep;
        logic [63:0] cause;
        logic [31:0] seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        commit = 1'b0;
    logic        stall_exe = 1'b0;
    logic [63:0] pc = 64'd0;
    logic [31:0] instr = 32'd0;
    logic [4:0]  xreg_dest = 5'd0;
    logic        wr_en = 1'b0;
    logic [63:0] commit_data = 64'd0;
    logic        excep = 1'b0;
    logic        csr_excep_valid = 1'b0;
    logic [63:0] csr_cause = 64'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_dest;
    logic [63:0] out_data;
    logic        out_wr_valid;
    logic        out_excep;
    logic [63:0] out_cause;
    logic [31:0] out_seq;
    logic        armed;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_seq = 32'd0;

    always #5 clk = ~clk;

    commit_trace_fifo #(.DEPTH(8), .START_PC(StartPc)) dut (
        .clk(clk), .rstn(rstn), .commit(commit), .stall_exe(stall_exe), .pc(pc),
        .instr(instr), .xreg_dest(xreg_dest), .wr_en(wr_en), .commit_data(commit_data),
        .excep(excep), .csr_excep_valid(csr_excep_valid), .csr_cause(csr_cause),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_dest(out_dest), .out_data(out_data), .out_wr_valid(out_wr_valid),
        .out_excep(out_excep), .out_cause(out_cause), .out_seq(out_seq), .armed(armed),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // One cycle of stimulus; cap says whether this event is expected to be stored.
    task automatic ev(input logic [63:0] p, input logic [31:0] ins, input logic [4:0] d,
                      input logic we, input logic [63:0] dat, input logic ex, input logic cx,
                      input logic [63:0] cs, input logic stall, input logic cap);
        exp_t e;
        commit = 1'b1; stall_exe = stall; pc = p; instr = ins; xreg_dest = d; wr_en = we;
        commit_data = dat; excep = ex; csr_excep_valid = cx; csr_cause = cs;
        if (cap) begin
            e.pc = p; e.instr = ins; e.dest = d; e.data = dat;
            e.wr_valid = we && (d != 5'd0);
            e.excep = ex || cx;
            e.cause = (ex || cx) ? cs : 64'd0;
            e.seq = exp_seq;
            exp_seq = exp_seq + 32'd1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        commit = 1'b0; stall_exe = 1'b0;
    endtask

    task automatic evp(input logic [63:0] p, input logic cap);
        ev(p, p[31:0] ^ 32'h0000_0013, p[6:2] | 5'd1, 1'b1, p * 3, 1'b0, 1'b0, 64'hdead,
           1'b0, cap);
    endtask

    task automatic do_reset();
        rstn = 1'b0; out_ready = 1'b0; commit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sb_q.delete();
        exp_seq = 32'd0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (count == 4'd0) break;
            @(posedge clk);
            #1;
        end
        chk({name, "_empty"}, 64'(count), 64'd0);
        chk({name, "_sb_left"}, 64'(sb_q.size()), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rstn && out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_pop: got seq %0d want none", out_seq);
                    end else begin
                        exp_t e;
                        exp_t g;
                        e = sb_q.pop_front();
                        g = '{out_pc, out_instr, out_dest, out_data, out_wr_valid,
                              out_excep, out_cause, out_seq};
                        total++;
                        if (g !== e) begin
                            bad++;
                            $display("FAIL entry_seq%0d: got %h want %h", e.seq, g, e);
                        end
                    end
                end
            end
        join_none

        // Reset state
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);

        // Arming
        evp(64'h1000, 1'b0);
        chk("arm_ignored_count", 64'(count), 64'd0);
        evp(64'h1004, 1'b0);
        chk("arm_ignored_armed", 64'(armed), 64'd0);
        evp(StartPc, 1'b1);
        chk("arm_count", 64'(count), 64'd1);
        chk("arm_armed", 64'(armed), 64'd1);
        chk("arm_seq", 64'(out_seq), 64'd0);
        chk("arm_pc", out_pc, StartPc);
        drain("arm");

        // Throughput: 20 back-to-back events, consumer always ready
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            evp(StartPc + 64'(4 * i), 1'b1);
            chk("tput_count_le1", 64'(count <= 4'd1), 64'd1);
        end
        chk("tput_overflow", 64'(overflow), 64'd0);
        drain("tput");

        // Overflow: 10 events into an 8-deep FIFO, last two dropped
        do_reset();
        for (int i = 0; i < 10; i++) begin
            evp(StartPc + 64'(4 * i), i < 8);
        end
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        chk("ovf_head_seq", 64'(out_seq), 64'd0);
        // Full with simultaneous pop: push accepted with seq 8
        out_ready = 1'b1;
        evp(StartPc + 64'h100, 1'b1);
        chk("fullpop_count", 64'(count), 64'd8);
        chk("fullpop_drop", 64'(drop_cnt), 64'd2);
        drain("ovf");
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Field rules
        do_reset();
        ev(StartPc, 32'h0000_0093, 5'd0, 1'b1, 64'h55, 1'b0, 1'b0, 64'h9, 1'b0, 1'b1);
        chk("field_wr_valid_x0", 64'(out_wr_valid), 64'd0);
        ev(StartPc + 4, 32'h0000_0073, 5'd3, 1'b1, 64'h66, 1'b0, 1'b1, 64'h2, 1'b0, 1'b1);
        ev(StartPc + 8, 32'h0000_0013, 5'd4, 1'b0, 64'h77, 1'b1, 1'b0, 64'h5, 1'b0, 1'b1);
        ev(StartPc + 12, 32'h0000_0033, 5'd5, 1'b1, 64'h88, 1'b0, 1'b0, 64'h7, 1'b0, 1'b1);
        ev(StartPc + 16, 32'h0000_0013, 5'd6, 1'b1, 64'h99, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        chk("field_stall_count", 64'(count), 64'd4);
        drain("field");

        // Reset mid-stream concurrent with an event
        do_reset();
        for (int i = 0; i < 5; i++) begin
            evp(StartPc + 64'(4 * i), 1'b1);
        end
        chk("mid_count5", 64'(count), 64'd5);
        rstn = 1'b0;
        commit = 1'b1; pc = StartPc + 64'h40;
        @(posedge clk);
        #1;
        rstn = 1'b1; commit = 1'b0;
        sb_q.delete();
        exp_seq = 32'd0;
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_armed", 64'(armed), 64'd0);
        chk("mid_drop", 64'(drop_cnt), 64'd0);
        chk("mid_valid", 64'(out_valid), 64'd0);
        evp(64'h1000, 1'b0);
        chk("mid_rearm_count", 64'(count), 64'd0);
        chk("mid_rearm_armed", 64'(armed), 64'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
